// File: rtl/k2_exec_controller.sv
// Execution controller for a small processor: owns a 16x8 program memory, loads it
// byte-serially, and sequences reset/run/pause/single-step with halt and cycle-limit detection.
module k2_exec_controller #(
  parameter int MAX_CYCLES = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  output logic       load_ready,
  input  logic       start,
  input  logic       step,
  input  logic       stop,
  input  logic [3:0] pc_addr,
  output logic [7:0] instr,
  output logic       cpu_pc_en,
  output logic       cpu_rst_n,
  output logic       busy,
  output logic       halted,
  output logic       timeout,
  output logic [7:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_CPU_RST, S_RUN, S_STEP, S_PAUSE, S_DONE
  } state_t;

  localparam logic [7:0] CYC_LIMIT = 8'(MAX_CYCLES);

  state_t      state, state_nxt;
  logic [7:0]  mem [16];
  logic [3:0]  wr_ptr;
  logic [7:0]  cyc_cnt;
  logic        running, halt_det, exec, limit_hit, accept, start_run;

  always_comb begin
    instr      = mem[pc_addr];
    running    = (state == S_RUN) || (state == S_STEP);
    // A jump whose target is its own address can never make progress: treat it as halt.
    halt_det   = running && (instr[7:6] == 2'b10) && ({1'b0, instr[2:0]} == pc_addr);
    exec       = running && !halt_det;
    limit_hit  = exec && ((cyc_cnt + 8'd1) == CYC_LIMIT);
    load_ready = (state == S_IDLE) || (state == S_DONE);
    accept     = load_valid && load_ready;
    start_run  = start && load_ready;
    cpu_pc_en  = exec && !rst;
    cpu_rst_n  = !rst && (state != S_IDLE) && (state != S_CPU_RST);
    busy       = (state == S_CPU_RST) || (state == S_RUN) ||
                 (state == S_STEP) || (state == S_PAUSE);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_CPU_RST;
      S_CPU_RST:      state_nxt = S_RUN;
      S_RUN: begin
        if (halt_det)       state_nxt = S_DONE;
        else if (limit_hit) state_nxt = S_DONE;
        else if (stop)      state_nxt = S_PAUSE;
      end
      S_STEP: begin
        if (halt_det || limit_hit) state_nxt = S_DONE;
        else                       state_nxt = S_PAUSE;
      end
      S_PAUSE: begin
        if (stop)       state_nxt = S_DONE;
        else if (start) state_nxt = S_RUN;
        else if (step)  state_nxt = S_STEP;
      end
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      wr_ptr      <= 4'd0;
      cyc_cnt     <= 8'd0;
      instr_count <= 8'd0;
      halted      <= 1'b0;
      timeout     <= 1'b0;
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
    end else begin
      state <= state_nxt;
      if (accept) begin
        mem[wr_ptr] <= load_data;
        wr_ptr      <= wr_ptr + 4'd1;
      end
      // A new run always restarts loading at address 0, even if a byte lands this cycle.
      if (start_run) begin
        wr_ptr      <= 4'd0;
        cyc_cnt     <= 8'd0;
        instr_count <= 8'd0;
        halted      <= 1'b0;
        timeout     <= 1'b0;
      end
      if (exec) begin
        cyc_cnt <= cyc_cnt + 8'd1;
        if (instr_count != 8'hFF) instr_count <= instr_count + 8'd1;
      end
      if (halt_det)  halted  <= 1'b1;
      if (limit_hit) timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_k2_exec_controller.sv
// Bench for k2_exec_controller: directed scenarios plus a randomized run checked against
// a behavioural model of the controller and a tiny counting processor that drives pc_addr.
module tb_k2_exec_controller;
  localparam int MAXC = 20;

  logic       clk = 1'b0;
  logic       rst, load_valid, start, step, stop;
  logic [7:0] load_data;
  logic [3:0] pc_addr;
  logic       load_ready, cpu_pc_en, cpu_rst_n, busy, halted, timeout;
  logic [7:0] instr, instr_count;

  always #5 clk = ~clk;

  k2_exec_controller #(.MAX_CYCLES(MAXC)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .start(start), .step(step), .stop(stop),
    .pc_addr(pc_addr), .instr(instr), .cpu_pc_en(cpu_pc_en), .cpu_rst_n(cpu_rst_n),
    .busy(busy), .halted(halted), .timeout(timeout), .instr_count(instr_count)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Behavioural model
  string      m_st = "IDLE";
  logic [7:0] m_mem [16];
  int         m_wp = 0, m_cnt = 0, m_cyc = 0;
  bit         m_halted = 0, m_timeout = 0, m_halt_now = 0;
  logic       e_ready, e_pc_en, e_rst_n, e_busy;
  logic [7:0] e_instr;

  // Processor stand-in: counts up when enabled, clears while held in reset.
  logic [3:0] cpu_pc = 4'd0;
  bit         use_cpu = 1;
  logic [3:0] fpc = 4'd0;

  task automatic drive(input bit r, input bit lv, input logic [7:0] ld,
                       input bit sa, input bit st, input bit sp);
    bit run_now;
    @(negedge clk);
    rst = r; load_valid = lv; load_data = ld; start = sa; step = st; stop = sp;
    pc_addr = use_cpu ? cpu_pc : fpc;
    #1;
    run_now    = (m_st == "RUN") || (m_st == "STEP");
    e_instr    = m_mem[pc_addr];
    m_halt_now = run_now && (e_instr[7:6] == 2'b10) && ({1'b0, e_instr[2:0]} == pc_addr);
    e_ready    = (m_st == "IDLE") || (m_st == "DONE");
    e_pc_en    = !r && run_now && !m_halt_now;
    e_rst_n    = !r && !((m_st == "IDLE") || (m_st == "CPU_RST"));
    e_busy     = (m_st == "CPU_RST") || (m_st == "RUN") || (m_st == "STEP") || (m_st == "PAUSE");
  endtask

  task automatic advance();
    bit pce, rn;
    pce = cpu_pc_en; rn = cpu_rst_n;
    @(posedge clk);
    if (rst) begin
      m_st = "IDLE"; m_wp = 0; m_cnt = 0; m_cyc = 0; m_halted = 0; m_timeout = 0;
      for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    end else begin
      if (((m_st == "IDLE") || (m_st == "DONE")) && load_valid) begin
        m_mem[m_wp] = load_data;
        m_wp = (m_wp + 1) % 16;
      end
      if ((m_st == "IDLE") || (m_st == "DONE")) begin
        if (start) begin
          m_wp = 0; m_cnt = 0; m_cyc = 0; m_halted = 0; m_timeout = 0; m_st = "CPU_RST";
        end
      end else if (m_st == "CPU_RST") begin
        m_st = "RUN";
      end else if ((m_st == "RUN") || (m_st == "STEP")) begin
        if (m_halt_now) begin
          m_halted = 1; m_st = "DONE";
        end else begin
          m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
          m_cyc = m_cyc + 1;
          if (m_cyc == MAXC) begin m_timeout = 1; m_st = "DONE"; end
          else if (m_st == "STEP") m_st = "PAUSE";
          else if (stop) m_st = "PAUSE";
        end
      end else if (m_st == "PAUSE") begin
        if (stop) m_st = "DONE";
        else if (start) m_st = "RUN";
        else if (step) m_st = "STEP";
      end
    end
    if (!rn) cpu_pc = 4'd0;
    else if (pce) cpu_pc = cpu_pc + 4'd1;
  endtask

  task automatic tick(input bit r, input bit lv, input logic [7:0] ld,
                      input bit sa, input bit st, input bit sp);
    drive(r, lv, ld, sa, st, sp);
    advance();
  endtask

  task automatic test_reset();
    drive(1, 0, 8'h00, 0, 0, 0);
    n_vec++; if (cpu_pc_en !== 1'b0) begin n_bad++; $display("FAIL rst_pc_en got %b want 0", cpu_pc_en); end
    n_vec++; if (cpu_rst_n !== 1'b0) begin n_bad++; $display("FAIL rst_cpu_rst_n got %b want 0", cpu_rst_n); end
    advance();
    drive(0, 0, 8'h00, 0, 0, 0);
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
    n_vec++; if (load_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready got %b want 1", load_ready); end
    n_vec++; if (cpu_rst_n !== 1'b0) begin n_bad++; $display("FAIL idle_cpu_rst_n got %b want 0", cpu_rst_n); end
    n_vec++; if (instr_count !== 8'd0) begin n_bad++; $display("FAIL rst_count got %0d want 0", instr_count); end
    n_vec++; if ({halted, timeout} !== 2'b00) begin n_bad++; $display("FAIL rst_flags got %b want 00", {halted, timeout}); end
    n_vec++; if (instr !== 8'h00) begin n_bad++; $display("FAIL rst_instr got %h want 00", instr); end
    advance();
  endtask

  task automatic test_load_halt();
    tick(1, 0, 8'h00, 0, 0, 0);
    tick(0, 1, 8'h31, 0, 0, 0);
    tick(0, 1, 8'h81, 0, 0, 0);
    drive(0, 0, 8'h00, 1, 0, 0);
    advance();
    drive(0, 0, 8'h00, 0, 0, 0);
    n_vec++; if ({busy, cpu_rst_n, cpu_pc_en, load_ready} !== 4'b1000) begin n_bad++; $display("FAIL lh_cpu_rst got %b want 1000", {busy, cpu_rst_n, cpu_pc_en, load_ready}); end
    advance();
    drive(0, 0, 8'h00, 0, 0, 0);
    n_vec++; if (instr !== 8'h31) begin n_bad++; $display("FAIL lh_instr0 got %h want 31", instr); end
    n_vec++; if ({cpu_pc_en, cpu_rst_n} !== 2'b11) begin n_bad++; $display("FAIL lh_run got %b want 11", {cpu_pc_en, cpu_rst_n}); end
    advance();
    drive(0, 0, 8'h00, 0, 0, 0);
    n_vec++; if (instr !== 8'h81) begin n_bad++; $display("FAIL lh_instr1 got %h want 81", instr); end
    n_vec++; if (cpu_pc_en !== 1'b0) begin n_bad++; $display("FAIL lh_halt_pc_en got %b want 0", cpu_pc_en); end
    advance();
    drive(0, 0, 8'h00, 0, 0, 0);
    n_vec++; if ({busy, halted, timeout, load_ready} !== 4'b0101) begin n_bad++; $display("FAIL lh_done got %b want 0101", {busy, halted, timeout, load_ready}); end
    n_vec++; if (instr_count !== 8'd1) begin n_bad++; $display("FAIL lh_count got %0d want 1", instr_count); end
    advance();
  endtask

  task automatic test_timeout();
    int n_en, n_cyc;
    bit wrap, ended;
    logic [3:0] prev;
    n_en = 0; wrap = 0; ended = 0; prev = 4'd0;
    tick(1, 0, 8'h00, 0, 0, 0);
    tick(0, 0, 8'h00, 1, 0, 0);
    for (n_cyc = 0; n_cyc < 100; n_cyc++) begin
      drive(0, 0, 8'h00, 0, 0, 0);
      if (busy === 1'b0) begin ended = 1; break; end
      if (cpu_pc_en === 1'b1) n_en++;
      if (prev == 4'd15 && pc_addr == 4'd0) wrap = 1;
      prev = pc_addr;
      advance();
    end
    n_vec++; if (!ended) begin n_bad++; $display("FAIL to_end got busy after %0d cycles want DONE", n_cyc); end
    n_vec++; if (n_en != MAXC) begin n_bad++; $display("FAIL to_pc_en got %0d want %0d", n_en, MAXC); end
    n_vec++; if ({timeout, halted} !== 2'b10) begin n_bad++; $display("FAIL to_flags got %b want 10", {timeout, halted}); end
    n_vec++; if (instr_count !== 8'(MAXC)) begin n_bad++; $display("FAIL to_count got %0d want %0d", instr_count, MAXC); end
    n_vec++; if (!wrap) begin n_bad++; $display("FAIL to_wrap got 0 want 1"); end
    advance();
  endtask

  task automatic test_pause_step();
    logic [3:0] pc0;
    int pulses;
    tick(1, 0, 8'h00, 0, 0, 0);
    tick(0, 0, 8'h00, 1, 0, 0);
    tick(0, 0, 8'h00, 0, 0, 0);
    tick(0, 0, 8'h00, 0, 0, 0);
    tick(0, 0, 8'h00, 0, 0, 0);
    drive(0, 0, 8'h00, 0, 0, 1);
    n_vec++; if (cpu_pc_en !== 1'b1) begin n_bad++; $display("FAIL ps_stop_exec got %b want 1", cpu_pc_en); end
    advance();
    drive(0, 0, 8'h00, 0, 0, 0);
    pc0 = pc_addr;
    advance();
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 8'h00, 0, 0, 0);
      n_vec++; if ({busy, cpu_pc_en} !== 2'b10) begin n_bad++; $display("FAIL ps_pause got %b want 10", {busy, cpu_pc_en}); end
      n_vec++; if (pc_addr !== pc0) begin n_bad++; $display("FAIL ps_frozen got %0d want %0d", pc_addr, pc0); end
      advance();
    end
    n_vec++; if (instr_count !== 8'd3) begin n_bad++; $display("FAIL ps_count0 got %0d want 3", instr_count); end
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 8'h00, 0, 1, 0); if (cpu_pc_en === 1'b1) pulses++; advance();
      drive(0, 0, 8'h00, 0, 0, 0); if (cpu_pc_en === 1'b1) pulses++; advance();
      drive(0, 0, 8'h00, 0, 0, 0); if (cpu_pc_en === 1'b1) pulses++; advance();
    end
    n_vec++; if (pulses != 3) begin n_bad++; $display("FAIL ps_pulses got %0d want 3", pulses); end
    n_vec++; if (instr_count !== 8'd6) begin n_bad++; $display("FAIL ps_count got %0d want 6", instr_count); end
    tick(0, 0, 8'h00, 1, 0, 0);
    drive(0, 0, 8'h00, 0, 0, 0);
    n_vec++; if ({cpu_pc_en, cpu_rst_n, busy} !== 3'b111) begin n_bad++; $display("FAIL ps_resume got %b want 111", {cpu_pc_en, cpu_rst_n, busy}); end
    advance();
    tick(0, 0, 8'h00, 0, 0, 1);
    tick(0, 0, 8'h00, 0, 0, 1);
  endtask

  task automatic test_priority();
    tick(1, 0, 8'h00, 0, 0, 0);
    tick(0, 1, 8'h00, 0, 0, 0);
    tick(0, 1, 8'h81, 0, 0, 0);
    tick(0, 0, 8'h00, 1, 0, 0);
    tick(0, 0, 8'h00, 0, 0, 0);
    tick(0, 0, 8'h00, 0, 0, 0);
    drive(0, 0, 8'h00, 0, 0, 1);
    n_vec++; if (cpu_pc_en !== 1'b0) begin n_bad++; $display("FAIL pr_halt_pc_en got %b want 0", cpu_pc_en); end
    advance();
    drive(0, 0, 8'h00, 0, 0, 0);
    n_vec++; if ({busy, halted} !== 2'b01) begin n_bad++; $display("FAIL pr_halt_stop got %b want 01", {busy, halted}); end
    advance();
    drive(0, 0, 8'h00, 0, 0, 0);
    n_vec++; if (halted !== 1'b1) begin n_bad++; $display("FAIL pr_sticky got %b want 1", halted); end
    advance();
    tick(1, 0, 8'h00, 0, 0, 0);
    tick(0, 0, 8'h00, 1, 0, 0);
    tick(0, 0, 8'h00, 0, 0, 0);
    tick(0, 0, 8'h00, 0, 0, 1);
    tick(0, 0, 8'h00, 1, 1, 0);
    drive(0, 0, 8'h00, 0, 0, 0);
    n_vec++; if (cpu_pc_en !== 1'b1) begin n_bad++; $display("FAIL pr_ss_run1 got %b want 1", cpu_pc_en); end
    advance();
    drive(0, 0, 8'h00, 0, 0, 0);
    n_vec++; if (cpu_pc_en !== 1'b1) begin n_bad++; $display("FAIL pr_ss_run2 got %b want 1", cpu_pc_en); end
    advance();
    tick(0, 0, 8'h00, 0, 0, 1);
    tick(0, 0, 8'h00, 0, 0, 1);
  endtask

  task automatic test_load_gating();
    logic [7:0] want;
    tick(1, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick(0, 1, 8'(8'h11 * (i + 1)), 0, 0, 0);
    tick(0, 0, 8'h00, 1, 0, 0);
    tick(0, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 8'hFF, 0, 0, 0);
      n_vec++; if (load_ready !== 1'b0) begin n_bad++; $display("FAIL lg_ready got %b want 0", load_ready); end
      advance();
    end
    tick(0, 0, 8'h00, 0, 0, 1);
    tick(0, 0, 8'h00, 0, 0, 1);
    use_cpu = 0;
    for (int i = 0; i < 5; i++) begin
      fpc = 4'(i);
      want = (i < 4) ? 8'(8'h11 * (i + 1)) : 8'h00;
      drive(0, 0, 8'h00, 0, 0, 0);
      n_vec++; if (instr !== want) begin n_bad++; $display("FAIL lg_mem[%0d] got %h want %h", i, instr, want); end
      advance();
    end
    tick(1, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 17; i++) tick(0, 1, 8'(8'h40 + i), 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      fpc = (i == 2) ? 4'd15 : 4'(i);
      want = (i == 0) ? 8'h50 : (i == 1) ? 8'h41 : 8'h4F;
      drive(0, 0, 8'h00, 0, 0, 0);
      n_vec++; if (instr !== want) begin n_bad++; $display("FAIL lg_wrap[%0d] got %h want %h", fpc, instr, want); end
      advance();
    end
    use_cpu = 1;
  endtask

  task automatic test_reset_mid_run();
    tick(1, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 16; i++) tick(0, 1, 8'(i + 1), 0, 0, 0);
    tick(0, 0, 8'h00, 1, 0, 0);
    tick(0, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick(0, 0, 8'h00, 0, 0, 0);
    drive(1, 0, 8'h00, 0, 0, 0);
    n_vec++; if ({cpu_pc_en, cpu_rst_n} !== 2'b00) begin n_bad++; $display("FAIL rm_during got %b want 00", {cpu_pc_en, cpu_rst_n}); end
    advance();
    drive(0, 0, 8'h00, 0, 0, 0);
    n_vec++; if ({busy, cpu_rst_n, load_ready} !== 3'b001) begin n_bad++; $display("FAIL rm_idle got %b want 001", {busy, cpu_rst_n, load_ready}); end
    n_vec++; if (instr_count !== 8'd0) begin n_bad++; $display("FAIL rm_count got %0d want 0", instr_count); end
    n_vec++; if (instr !== 8'h00) begin n_bad++; $display("FAIL rm_instr got %h want 00", instr); end
    advance();
  endtask

  task automatic test_random();
    bit r, lv, sa, st, sp;
    logic [7:0] ld;
    tick(1, 0, 8'h00, 0, 0, 0);
    for (int c = 0; c < 800; c++) begin
      r  = ($urandom_range(0, 99) == 0);
      lv = ($urandom_range(0, 2) == 0);
      ld = 8'($urandom);
      sa = ($urandom_range(0, 7) == 0);
      st = ($urandom_range(0, 5) == 0);
      sp = ($urandom_range(0, 11) == 0);
      drive(r, lv, ld, sa, st, sp);
      n_vec++; if (load_ready !== e_ready) begin n_bad++; $display("FAIL rnd_ready c%0d got %b want %b", c, load_ready, e_ready); end
      n_vec++; if (instr !== e_instr) begin n_bad++; $display("FAIL rnd_instr c%0d got %h want %h", c, instr, e_instr); end
      n_vec++; if (cpu_pc_en !== e_pc_en) begin n_bad++; $display("FAIL rnd_pc_en c%0d got %b want %b", c, cpu_pc_en, e_pc_en); end
      n_vec++; if (cpu_rst_n !== e_rst_n) begin n_bad++; $display("FAIL rnd_rst_n c%0d got %b want %b", c, cpu_rst_n, e_rst_n); end
      n_vec++; if (busy !== e_busy) begin n_bad++; $display("FAIL rnd_busy c%0d got %b want %b", c, busy, e_busy); end
      n_vec++; if (halted !== m_halted) begin n_bad++; $display("FAIL rnd_halted c%0d got %b want %b", c, halted, m_halted); end
      n_vec++; if (timeout !== m_timeout) begin n_bad++; $display("FAIL rnd_timeout c%0d got %b want %b", c, timeout, m_timeout); end
      n_vec++; if (instr_count !== 8'(m_cnt)) begin n_bad++; $display("FAIL rnd_count c%0d got %0d want %0d", c, instr_count, m_cnt); end
      advance();
    end
  endtask

  initial begin
    rst = 1; load_valid = 0; load_data = 8'h00; start = 0; step = 0; stop = 0; pc_addr = 4'd0;
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    test_reset();
    test_load_halt();
    test_timeout();
    test_pause_step();
    test_priority();
    test_load_gating();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/k2_exec_controller.md
K2_EXEC_CONTROLLER -- requirements
Module: k2_exec_controller

Interface
REQ-001 SHALL have parameter MAX_CYCLES, default 200 (8-bit range 1..255): executed-cycle limit per run before forced stop.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 load_valid  in  1  program byte offered.
REQ-006 load_data  in  8  program byte, written to program memory at the write pointer.
REQ-007 load_ready  out  1  program byte accepted when load_valid & load_ready.
REQ-008 start  in  1  one-cycle command: begin run (from IDLE/DONE) or resume (from PAUSE).
REQ-009 step  in  1  one-cycle command: execute exactly one instruction from PAUSE.
REQ-010 stop  in  1  one-cycle command: pause (from RUN) or end (from PAUSE).
REQ-011 pc_addr  in  4  processor program address.
REQ-012 instr  out  8  instruction word to processor; bit7 J, bit6 C, bits5:4 D, bit3 S, bits2:0 imm.
REQ-013 cpu_pc_en  out  1  processor program-counter enable.
REQ-014 cpu_rst_n  out  1  processor reset, active-low.
REQ-015 busy  out  1  high in CPU_RST, RUN, STEP, PAUSE.
REQ-016 halted  out  1  sticky: run ended on self-jump.
REQ-017 timeout  out  1  sticky: run ended on MAX_CYCLES.
REQ-018 instr_count  out  8  instructions executed this run, saturating at 255.

Function
REQ-019 SHALL hold a 16x8 program memory; instr = mem[pc_addr] combinationally, same cycle.
REQ-020 SHALL implement states IDLE, CPU_RST, RUN, STEP, PAUSE, DONE.
REQ-021 load_ready SHALL be 1 only in IDLE and DONE; an accepted byte writes mem[wr_ptr], and wr_ptr increments mod 16 (15 wraps to 0).
REQ-022 start in IDLE/DONE SHALL: clear wr_ptr, instr_count, cycle counter, halted, timeout; enter CPU_RST for exactly 1 cycle; then enter RUN.
REQ-023 cpu_rst_n SHALL be 0 in IDLE and CPU_RST, and 1 in all other states.
REQ-024 cpu_pc_en SHALL be 1 only in RUN and STEP, except it SHALL be 0 in any cycle where halt is detected (REQ-025).
REQ-025 Halt SHALL be detected combinationally in RUN/STEP when instr[7:6]==2'b10 and {1'b0,instr[2:0]}==pc_addr; the next state SHALL be DONE with halted=1, and that cycle is not counted.
REQ-026 Each cycle with cpu_pc_en=1 SHALL increment instr_count (saturating) and the 8-bit cycle counter.
REQ-027 When the cycle counter reaches MAX_CYCLES after an executed cycle, the next state SHALL be DONE with timeout=1.
REQ-028 stop in RUN SHALL enter PAUSE next cycle, and the stop cycle itself still executes.
REQ-029 In PAUSE: step SHALL enter STEP (1 cycle, one instruction) and then return to PAUSE; start SHALL resume RUN without a CPU reset; stop SHALL enter DONE.
REQ-030 Same-cycle event priority SHALL be: rst > halt > timeout > stop > start > step.
REQ-031 Commands SHALL be ignored in states where they are not listed above; load_valid SHALL be ignored while load_ready=0.
REQ-032 halted and timeout SHALL stay set until the next accepted start or rst.

Reset
REQ-033 rst SHALL force, on the next edge, state=IDLE, wr_ptr=0, all mem words=0x00, instr_count=0, halted=0, timeout=0, cycle counter=0.
REQ-034 rst SHALL take effect from any state, including mid-run and mid-load; in that cycle cpu_pc_en=0 and cpu_rst_n=0.

Verification
REQ-035 Load and halt: load 0x31,0x81, then start -> one CPU_RST cycle, RUN executes addr 0, halt detected at addr 1, DONE, halted=1, instr_count=1.
REQ-036 Timeout: all 16 words 0x00, MAX_CYCLES=20, start -> DONE after exactly 20 cpu_pc_en cycles, timeout=1, pc wraps 15->0.
REQ-037 Pause/step: stop during RUN -> PAUSE, pc_addr frozen; three step pulses -> exactly three single cpu_pc_en pulses and instr_count +3; start -> RUN resumes.
REQ-038 Priority: stop asserted in the same cycle as a halt-detect -> DONE with halted=1, not PAUSE; start and step together in PAUSE -> RUN.
REQ-039 Load gating: load_valid held during RUN -> load_ready=0 and mem unchanged; 17 bytes in IDLE -> the 17th overwrites mem[0].
REQ-040 Reset mid-run: rst at run cycle 5 -> IDLE next edge, cpu_rst_n=0, instr_count=0, and a subsequent instr read of 0x00.
